// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared constants, FSM states and record type for the MB scheduler
package me_pkg;

  localparam int FRAME_WIDTH     = 352;
  localparam int FRAME_HEIGHT    = 240;
  localparam int MB_SIZE         = 16;
  localparam int MB_COLS         = FRAME_WIDTH / MB_SIZE;
  localparam int MB_ROWS         = FRAME_HEIGHT / MB_SIZE;
  localparam int FIFO_DEPTH      = 8;
  localparam int WATCHDOG_CYCLES = 50000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_PUSH,
    ST_DRAIN
  } me_state_t;

  typedef struct packed {
    logic [4:0]        mb_x;
    logic [3:0]        mb_y;
    logic signed [5:0] mv_x;
    logic signed [5:0] mv_y;
    logic [15:0]       sad;
    logic              last;
  } me_rec_t;

endpackage

// File: rtl/me_rec_fifo.sv
// rtl/me_rec_fifo.sv - synchronous record FIFO with full/empty flags
// A push while full is accepted only when a pop frees a slot in the same cycle.
module me_rec_fifo
  import me_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  me_rec_t wr_data,
  input  logic    pop,
  output me_rec_t rd_data,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  me_rec_t       mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Empty reads return zero so the record outputs are clean out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/me_mb_scheduler.sv
// rtl/me_mb_scheduler.sv - raster-order macroblock sequencer feeding the hexbs ME core
// Optional per-MB watchdog is built when ME_WATCHDOG_EN is defined.
module me_mb_scheduler #(
  parameter int FRAME_WIDTH     = me_pkg::FRAME_WIDTH,
  parameter int FRAME_HEIGHT    = me_pkg::FRAME_HEIGHT,
  parameter int MB_SIZE         = me_pkg::MB_SIZE,
  parameter int FIFO_DEPTH      = me_pkg::FIFO_DEPTH,
  parameter int WATCHDOG_CYCLES = me_pkg::WATCHDOG_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic [31:0]        cur_base,
  input  logic [31:0]        ref_base,
  output logic               frame_busy,
  output logic               frame_done,
  output logic               me_start,
  output logic [31:0]        me_frame_start_addr,
  output logic [31:0]        me_ref_start_addr,
  output logic [31:0]        me_mb_x,
  output logic [31:0]        me_mb_y,
  input  logic signed [5:0]  me_mv_x,
  input  logic signed [5:0]  me_mv_y,
  input  logic [15:0]        me_sad,
  input  logic               me_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4:0]         out_mb_x,
  output logic [3:0]         out_mb_y,
  output logic signed [5:0]  out_mv_x,
  output logic signed [5:0]  out_mv_y,
  output logic [15:0]        out_sad,
  output logic               out_last,
  output logic               err_timeout
);

  import me_pkg::*;

  localparam int         COLS   = FRAME_WIDTH / MB_SIZE;
  localparam int         ROWS   = FRAME_HEIGHT / MB_SIZE;
  localparam logic [4:0] LAST_X = 5'(COLS - 1);
  localparam logic [3:0] LAST_Y = 4'(ROWS - 1);

  me_state_t         state, state_nxt;
  logic [4:0]        mb_x;
  logic [3:0]        mb_y;
  logic signed [5:0] cap_mv_x, cap_mv_y;
  logic [15:0]       cap_sad;
  logic              is_last, fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic              timeout, rec_done, last_popped;
  me_rec_t           wr_rec, rd_rec;

  assign is_last     = (mb_x == LAST_X) && (mb_y == LAST_Y);
  assign fifo_push   = (state == ST_PUSH) && !fifo_full;
  assign fifo_pop    = out_valid && out_ready;
  assign last_popped = fifo_pop && rd_rec.last;
  assign rec_done    = (state == ST_WAIT) && (me_done || timeout);

`ifdef ME_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    wd_cnt <= '0;
    else if (state == ST_ISSUE) wd_cnt <= '0;
    else if (state == ST_WAIT)  wd_cnt <= wd_cnt + WD_W'(1);
  end

  assign timeout = (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1)) && !me_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   err_timeout <= 1'b0;
    else if (state == ST_IDLE && frame_start)  err_timeout <= 1'b0;
    else if (state == ST_WAIT && timeout)      err_timeout <= 1'b1;
  end
`else
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    me_start   = 1'b0;
    frame_busy = (state != ST_IDLE);
    unique case (state)
      ST_IDLE:  if (frame_start) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        me_start  = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT:  if (rec_done) state_nxt = ST_PUSH;
      ST_PUSH:  if (!fifo_full) state_nxt = is_last ? ST_DRAIN : ST_ISSUE;
      ST_DRAIN: if (last_popped) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      me_frame_start_addr <= '0;
      me_ref_start_addr   <= '0;
      mb_x                <= '0;
      mb_y                <= '0;
      cap_mv_x            <= '0;
      cap_mv_y            <= '0;
      cap_sad             <= '0;
      frame_done          <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        ST_IDLE: if (frame_start) begin
          me_frame_start_addr <= cur_base;
          me_ref_start_addr   <= ref_base;
          mb_x                <= '0;
          mb_y                <= '0;
        end
        ST_WAIT: if (me_done) begin
          cap_mv_x <= me_mv_x;
          cap_mv_y <= me_mv_y;
          cap_sad  <= me_sad;
        end else if (timeout) begin
          cap_mv_x <= '0;
          cap_mv_y <= '0;
          cap_sad  <= 16'hFFFF;
        end
        // Coordinates move only once the record is safely in the FIFO.
        ST_PUSH: if (!fifo_full && !is_last) begin
          if (mb_x == LAST_X) begin
            mb_x <= '0;
            mb_y <= mb_y + 4'd1;
          end else begin
            mb_x <= mb_x + 5'd1;
          end
        end
        ST_DRAIN: if (last_popped) frame_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign me_mb_x = {27'd0, mb_x};
  assign me_mb_y = {28'd0, mb_y};

  assign wr_rec = '{mb_x: mb_x, mb_y: mb_y, mv_x: cap_mv_x, mv_y: cap_mv_y,
                    sad: cap_sad, last: is_last};

  me_rec_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (wr_rec),
    .pop     (fifo_pop),
    .rd_data (rd_rec),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_mb_x  = rd_rec.mb_x;
  assign out_mb_y  = rd_rec.mb_y;
  assign out_mv_x  = rd_rec.mv_x;
  assign out_mv_y  = rd_rec.mv_y;
  assign out_sad   = rd_rec.sad;
  assign out_last  = rd_rec.last;

endmodule
